bcd_to_e3_serial: RTL and testbench

- Parametrised, digit-serial successor to the single-digit combinational BCD-to-Excess-3 converter.
- Accepts a packed multi-digit BCD word over a valid/ready handshake.
- Converts one 4-bit digit per clock, LSB digit first.
- Returns the packed Excess-3 word with a per-digit invalid-code mask. Sits between the BCD datapath and the XS3 display/arithmetic stage.

---
 rtl/bcd_to_e3_serial.sv | 128 ++++++++++++
 tb/tb_bcd_to_e3_serial.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_e3_serial.sv
// bcd_to_e3_serial: digit-serial BCD <-> Excess-3 converter, one nibble per clock,
// LSB digit first, with valid/ready handshakes on both sides.
// Optional macro BCD_E3_DECODE_EN enables XS3->BCD decode selected by 'mode';
// without it 'mode' is ignored and every word is encoded.
module bcd_to_e3_serial #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  err,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     idx;
  logic [4*DIGITS-1:0]  cap_data;
  logic [3:0]           cur_digit;
  logic [3:0]           conv_nib;
  logic                 conv_bad;

`ifdef BCD_E3_DECODE_EN
  logic                 cap_mode;
`else
  logic                 unused_mode;
  assign unused_mode = mode;
`endif

  assign err = |err_mask;

  // Select the captured digit currently being converted.
  always_comb begin
    cur_digit = cap_data[{idx, 2'b00} +: 4];
  end

  // Convert one digit; invalid codes produce a zero nibble and flag an error.
  always_comb begin
    conv_nib = '0;
    conv_bad = 1'b0;
`ifdef BCD_E3_DECODE_EN
    if (cap_mode) begin
      if (cur_digit >= 4'd3 && cur_digit <= 4'd12) conv_nib = cur_digit - 4'd3;
      else                                         conv_bad = 1'b1;
    end else
`endif
    if (cur_digit <= 4'd9) conv_nib = cur_digit + 4'd3;
    else                   conv_bad = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CONV;
      end
      CONV: begin
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, per-digit conversion writeback, completed-word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      cap_data <= '0;
      out_data <= '0;
      err_mask <= '0;
      word_cnt <= '0;
`ifdef BCD_E3_DECODE_EN
      cap_mode <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_data <= in_data;
            out_data <= '0;
            err_mask <= '0;
            idx      <= '0;
`ifdef BCD_E3_DECODE_EN
            cap_mode <= mode;
`endif
          end
        end
        CONV: begin
          out_data[{idx, 2'b00} +: 4] <= conv_nib;
          err_mask[idx]               <= conv_bad;
          idx                         <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        DONE: begin
          if (out_ready) word_cnt <= word_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_e3_serial.sv
// Self-checking bench for bcd_to_e3_serial (DIGITS=4, CNT_W=8) against an
// arithmetic per-digit reference model.
module tb_bcd_to_e3_serial;

  localparam int DIGITS = 4;
  localparam int CNT_W  = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DIGITS-1:0]  in_data;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  out_data;
  logic [DIGITS-1:0]    err_mask;
  logic                 err;
  logic [CNT_W-1:0]     word_cnt;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  bcd_to_e3_serial #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_mask(err_mask), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: returns {err_mask, data} from digit arithmetic.
  function automatic logic [4*DIGITS+DIGITS-1:0] model(input logic [4*DIGITS-1:0] w, input logic m);
    logic [4*DIGITS-1:0] d;
    logic [DIGITS-1:0]   e;
    int unsigned         dig;
    int unsigned         res;
    bit                  dec;
    d = '0;
    e = '0;
`ifdef BCD_E3_DECODE_EN
    dec = m;
`else
    dec = 1'b0;
    if (m) dec = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      dig = (w >> (4 * i)) & 32'hF;
      res = 0;
      if (dec) begin
        if (dig >= 3 && dig <= 12) res = dig - 3;
        else e[i] = 1'b1;
      end else begin
        if (dig <= 9) res = dig + 3;
        else e[i] = 1'b1;
      end
      d = d | ((4*DIGITS)'(res) << (4 * i));
    end
    return {e, d};
  endfunction

  // Send one word, check latency, result, backpressure hold and handshake.
  task automatic run_word(input logic [15:0] w, input logic m, input int hold);
    logic [19:0] exp;
    int          lat;
    int          n;
    logic [15:0] held;
    exp = model(w, m);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_data   = w;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    mode     = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), DIGITS);
    check("out_data", 32'(out_data), 32'(exp[15:0]));
    check("err_mask", 32'(err_mask), 32'(exp[19:16]));
    check("err", 32'(err), 32'(|exp[19:16]));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    held = out_data;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data", 32'(out_data), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_word_cnt", 32'(word_cnt), 32'(cnt_model));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_model = cnt_model + 1'b1;
    check("word_cnt", 32'(word_cnt), 32'(cnt_model));
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
    out_ready = 1'($urandom);
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err_mask", 32'(err_mask), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);

    // Directed words including invalid-code boundaries.
    run_word(16'h1234, 1'b0, 0);
    run_word(16'h0009, 1'b0, 0);
    run_word(16'h9999, 1'b0, 0);
    run_word(16'h12A4, 1'b0, 0);
    run_word(16'hFFFF, 1'b0, 0);
    run_word(16'h4567, 1'b1, 0);
    run_word(16'h3D02, 1'b1, 0);
    run_word(16'h5678, 1'b0, 10);

    // Reset two cycles into conversion abandons the word.
    in_data = 16'h5678; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cnt_model = '0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_word_cnt", 32'(word_cnt), 32'd0);
    repeat (6) begin @(posedge clk); #1; end
    check("midrst_no_output", 32'(out_valid), 32'd0);
    run_word(16'h0001, 1'b0, 0);

    // Random words until the counter wraps past zero.
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0)
        for (int j = 0; j < DIGITS; j++) w[4*j +: 4] = 4'($urandom_range(0, 9));
      else
        w = 16'($urandom);
      run_word(w, 1'($urandom), (i % 37 == 0) ? 3 : 0);
    end
    check("wrap_word_cnt", 32'(word_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
